// File: rtl/mssd_frame_tx_if.sv
// Frame request channel into mssd_frame_tx.
//   inValid : source has a frame request
//   inReady : transmitter holding register is empty
//   inPort  : destination port (2b)
//   inLen   : payload length N, 0..15
//   inData  : payload, bits [N-1:0] are sent MSB first
interface mssd_frame_tx_if #(parameter int DATA_W = 15);
  logic              inValid;
  logic              inReady;
  logic [1:0]        inPort;
  logic [3:0]        inLen;
  logic [DATA_W-1:0] inData;

  modport master (output inValid, inPort, inLen, inData, input  inReady);
  modport slave  (input  inValid, inPort, inLen, inData, output inReady);
endinterface

// File: rtl/mssd_frame_tx.sv
// Serial frame transmitter feeding the MSSD receiver.
// A frame on serOut is: start(0), port[1:0], len[3:0], data[N-1:0] (all MSB
// first), then GAP_BITS idle ones. A one-deep holding register takes the next
// request while the current frame shifts out.
// Ports:
//   clk       : one serial bit per cycle
//   rst       : async active-low reset
//   req       : request channel (slave side), see mssd_frame_tx_if
//   serOut    : registered serial line, idles high
//   busy      : start bit through last gap bit
//   txPort    : port of frame in flight, holds when idle
//   frameDone : pulse in the first gap cycle
module mssd_frame_tx #(
  parameter int GAP_BITS = 2,
  parameter int DATA_W   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  mssd_frame_tx_if.slave       req,
  output logic                 serOut,
  output logic                 busy,
  output logic [1:0]           txPort,
  output logic                 frameDone
);
  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAP} st_t;

  st_t               r_state, w_state_n;
  logic [3:0]        r_cnt, w_cnt_n;
  logic [GW-1:0]     r_gcnt, w_gcnt_n;

  // frame in the shifter
  logic [1:0]        r_port, w_port_n;
  logic [3:0]        r_len, w_len_n;
  logic [DATA_W-1:0] r_data, w_data_n;

  // holding register
  logic              r_h_vld;
  logic [1:0]        r_h_port;
  logic [3:0]        r_h_len;
  logic [DATA_W-1:0] r_h_data;

  logic              r_ser, w_ser_n;
  logic [1:0]        r_txport;
  logic              w_acc, w_load_in, w_load_h;

  assign req.inReady = ~r_h_vld;
  assign w_acc       = req.inValid & ~r_h_vld;

  // r_cnt is the index of the bit currently on the line within its field;
  // r_gcnt counts gap bits remaining down to zero.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gcnt_n  = r_gcnt;
    w_load_in = 1'b0;
    w_load_h  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_h_vld) begin
          w_state_n = START; w_load_h = 1'b1;
        end else if (w_acc) begin
          w_state_n = START; w_load_in = 1'b1;
        end
      end
      START: begin
        w_state_n = PORT; w_cnt_n = 4'd1;
      end
      PORT: begin
        if (r_cnt == 4'd0) begin
          w_state_n = LEN; w_cnt_n = 4'd3;
        end else w_cnt_n = r_cnt - 4'd1;
      end
      LEN: begin
        if (r_cnt == 4'd0) begin
          if (r_len == 4'd0) begin
            w_state_n = GAP; w_gcnt_n = GAP_LAST;
          end else begin
            w_state_n = DATA; w_cnt_n = r_len - 4'd1;
          end
        end else w_cnt_n = r_cnt - 4'd1;
      end
      DATA: begin
        if (r_cnt == 4'd0) begin
          w_state_n = GAP; w_gcnt_n = GAP_LAST;
        end else w_cnt_n = r_cnt - 4'd1;
      end
      GAP: begin
        if (r_gcnt == '0) begin
          // held frame has priority; otherwise a request arriving on this
          // edge goes straight out for back-to-back framing
          if (r_h_vld) begin
            w_state_n = START; w_load_h = 1'b1;
          end else if (w_acc) begin
            w_state_n = START; w_load_in = 1'b1;
          end else w_state_n = IDLE;
        end else w_gcnt_n = r_gcnt - GW'(1);
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_port_n = r_port;
    w_len_n  = r_len;
    w_data_n = r_data;
    if (w_load_h) begin
      w_port_n = r_h_port; w_len_n = r_h_len; w_data_n = r_h_data;
    end else if (w_load_in) begin
      w_port_n = req.inPort; w_len_n = req.inLen; w_data_n = req.inData;
    end
  end

  // serOut is registered, so the next bit is chosen from next-state values
  always_comb begin
    w_ser_n = 1'b1;
    case (w_state_n)
      START:   w_ser_n = 1'b0;
      PORT:    w_ser_n = w_port_n[w_cnt_n[0]];
      LEN:     w_ser_n = w_len_n[w_cnt_n[1:0]];
      DATA:    w_ser_n = w_data_n[w_cnt_n];
      default: w_ser_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_port   <= '0;
      r_len    <= '0;
      r_data   <= '0;
      r_ser    <= 1'b1;
      r_txport <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_gcnt  <= w_gcnt_n;
      r_port  <= w_port_n;
      r_len   <= w_len_n;
      r_data  <= w_data_n;
      r_ser   <= w_ser_n;
      if (w_load_h | w_load_in) r_txport <= w_port_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_vld  <= 1'b0;
      r_h_port <= '0;
      r_h_len  <= '0;
      r_h_data <= '0;
    end else if (w_load_h) begin
      r_h_vld <= 1'b0;
    end else if (w_acc & ~w_load_in) begin
      r_h_vld  <= 1'b1;
      r_h_port <= req.inPort;
      r_h_len  <= req.inLen;
      r_h_data <= req.inData;
    end
  end

  assign serOut    = r_ser;
  assign busy      = (r_state != IDLE);
  assign txPort    = r_txport;
  assign frameDone = (r_state == GAP) && (r_gcnt == GAP_LAST);
endmodule

// File: tb/tb_mssd_frame_tx.sv
module tb_mssd_frame_tx;
  localparam int GAP_BITS = 2;
  localparam int DATA_W   = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       serOut, busy, frameDone;
  logic [1:0] txPort;

  mssd_frame_tx_if #(.DATA_W(DATA_W)) ifc ();

  mssd_frame_tx #(.GAP_BITS(GAP_BITS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(ifc.slave),
    .serOut(serOut), .busy(busy), .txPort(txPort), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  // one expected line cycle: serial bit, frameDone, frame port, start marker
  typedef struct packed {
    logic       ser;
    logic       done;
    logic [1:0] port;
    logic       st;
  } rec_t;

  rec_t       q[$];
  logic       m_ready;
  logic [1:0] m_txp;
  int         n_vec, n_err;
  logic       obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // expected line image of one frame, appended after whatever is queued
  task automatic push_frame(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
    q.push_back('{ser:1'b0, done:1'b0, port:p, st:1'b1});
    for (int i = 1; i >= 0; i--) q.push_back('{ser:p[i], done:1'b0, port:p, st:1'b0});
    for (int i = 3; i >= 0; i--) q.push_back('{ser:l[i], done:1'b0, port:p, st:1'b0});
    for (int i = int'(l) - 1; i >= 0; i--) q.push_back('{ser:d[i], done:1'b0, port:p, st:1'b0});
    for (int i = 0; i < GAP_BITS; i++) q.push_back('{ser:1'b1, done:(i == 0), port:p, st:1'b0});
  endtask

  // one clock: drive at negedge, model the edge, check 1 unit after it
  task automatic cyc(input logic v, input logic [1:0] p, input logic [3:0] l,
                     input logic [14:0] d, output logic acc);
    rec_t r;
    logic e_ser, e_busy, e_done;
    ifc.inValid = v; ifc.inPort = p; ifc.inLen = l; ifc.inData = d;
    acc = v & m_ready;
    @(posedge clk);
    if (acc) push_frame(p, l, d);
    if (q.size() != 0) begin
      r = q.pop_front();
      e_ser = r.ser; e_busy = 1'b1; e_done = r.done; m_txp = r.port;
    end else begin
      e_ser = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end
    m_ready = 1'b1;
    foreach (q[i]) if (q[i].st) m_ready = 1'b0;
    #1;
    obs = serOut;
    chk("serOut", 32'(serOut), 32'(e_ser));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frameDone", 32'(frameDone), 32'(e_done));
    chk("txPort", 32'(txPort), 32'(m_txp));
    chk("inReady", 32'(ifc.inReady), 32'(m_ready));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 2'($urandom), 4'($urandom), 15'($urandom), a);
  endtask

  task automatic rst_mid();
    #2 rst = 1'b0;
    #1;
    chk("rst_serOut", 32'(serOut), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inReady", 32'(ifc.inReady), 32'd1);
    chk("rst_frameDone", 32'(frameDone), 32'd0);
    chk("rst_txPort", 32'(txPort), 32'd0);
    q.delete(); m_ready = 1'b1; m_txp = 2'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        a, rv;
    logic [1:0]  rp;
    logic [3:0]  rl;
    logic [14:0] rd;
    logic [10:0] seq;
    int          k;
    n_vec = 0; n_err = 0;
    q.delete(); m_ready = 1'b1; m_txp = 2'd0;
    rst = 1'b0;
    ifc.inValid = 1'b0; ifc.inPort = '0; ifc.inLen = '0; ifc.inData = '0;
    repeat (2) @(negedge clk);
    chk("init_serOut", 32'(serOut), 32'd1);
    chk("init_inReady", 32'(ifc.inReady), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_txPort", 32'(txPort), 32'd0);
    chk("init_frameDone", 32'(frameDone), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // basic frame, bit sequence also checked against a literal image
    seq = '0;
    cyc(1'b1, 2'd3, 4'd2, 15'h0002, a);
    seq = {seq[9:0], obs};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'd0, 4'd7, 15'h7fff, a);
      seq = {seq[9:0], obs};
    end
    chk("t1_seq", 32'(seq), 32'(11'b01100101011));
    idle(3);

    // zero length and maximum length
    cyc(1'b1, 2'd1, 4'd0, 15'h7fff, a); idle(12);
    cyc(1'b1, 2'd2, 4'd15, 15'h5555, a); idle(28);

    // back-to-back with a third request stalled until B starts
    cyc(1'b1, 2'd0, 4'd3, 15'h0005, a);
    cyc(1'b1, 2'd2, 4'd5, 15'h0013, a);
    chk("t4_b_acc", 32'(a), 32'd1);
    k = 0;
    do begin
      cyc(1'b1, 2'd1, 4'd4, 15'h000a, a);
      k++;
    end while (!a && k < 40);
    chk("t4_third_wait", 32'(k), 32'd12);
    idle(40);

    // reset during DATA with a frame held
    cyc(1'b1, 2'd2, 4'd15, 15'h1234, a);
    cyc(1'b1, 2'd3, 4'd4, 15'h000f, a);
    idle(9);
    rst_mid();
    idle(6);
    cyc(1'b1, 2'd1, 4'd1, 15'h0001, a);
    idle(12);

    // random traffic; requests are held until accepted, then replaced
    rv = 1'b0; rp = '0; rl = '0; rd = '0; a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!rv || a) begin
        rv = ($urandom_range(0, 9) < 6);
        rp = 2'($urandom);
        case ($urandom_range(0, 5))
          0:       rl = 4'd0;
          1:       rl = 4'd15;
          default: rl = 4'($urandom);
        endcase
        rd = 15'($urandom);
      end
      cyc(rv, rp, rl, rd, a);
      if (!rv) a = 1'b1;
      if (i == 1500) rst_mid();
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mssd_frame_tx.md
Name: mssd_frame_tx

Overview:
- Serial frame transmitter that sits directly upstream of the MSSD receiver and drives its serial input from parallel frame requests.
- Each request (port, length, data) is emitted on serOut as:
  - one start bit (0)
  - 2 port bits, MSB first
  - 4 length bits, MSB first
  - N data bits, MSB first
  - GAP_BITS idle ones
- A one-deep holding register accepts the next frame while the current frame is being shifted out.

Parameters:
- GAP_BITS, 2, number of idle (1) bit-cycles forced after each frame; must be ≥1.
- DATA_W, 15, width of inData; equals the largest length encodable in 4 bits.

Ports:
- clk  input  1  clock; one serial bit per cycle.
- rst  input  1  asynchronous, active-low reset.
- inValid  input  1  frame request valid.
- inReady  output  1  holding register empty; a frame is accepted when inValid && inReady at a rising edge.
- inPort  input  2  destination port of the frame.
- inLen  input  4  number of data bits N (0..15).
- inData  input  DATA_W  payload; bits [N-1:0] are sent, starting with bit N-1; higher bits are ignored.
- serOut  output  1  registered serial line; idles at 1.
- busy  output  1  high from the start bit through the last gap bit.
- txPort  output  2  port of the frame currently in flight; holds its last value when idle.
- frameDone  output  1  one-cycle pulse in the first gap cycle of each frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - serOut=1, inReady=1, busy=0, txPort=0, frameDone=0.
  - FSM goes to IDLE; holding register is cleared.
  - Any frame in flight or held is dropped; no partial frame resumes after reset.
- FSM states: IDLE, START, PORT, LEN, DATA, GAP.
  - IDLE: serOut=1. Leave IDLE on acceptance, or when the holding register is full.
  - START: 1 cycle, serOut=0.
  - PORT: 2 cycles, port[1] then port[0].
  - LEN: 4 cycles, len[3] down to len[0].
  - DATA: N cycles, data[N-1] down to data[0]. Skipped entirely when N=0 (LEN goes directly to GAP).
  - GAP: GAP_BITS cycles, serOut=1. frameDone=1 in the first GAP cycle only.
  - At the end of GAP: go to START if the holding register is full (the held frame moves into the shifter and holding clears); otherwise go to IDLE.
- Latency and frame length:
  - Acceptance at edge E while in IDLE with holding empty: the frame loads directly into the shifter and serOut=0 (start bit) from edge E.
  - Frame occupies exactly 7+N+GAP_BITS cycles of busy.
- Holding register:
  - inReady = holding register empty.
  - Acceptance while in START..GAP fills the holding register.
  - Acceptance on the final GAP edge with holding empty: the frame goes straight to START, giving back-to-back frames with exactly GAP_BITS ones between them.
- Field capture:
  - inPort, inLen and inData are captured at acceptance; later changes on the inputs have no effect.
  - txPort updates when a frame enters START.
- inValid with inReady=0 is ignored; the source must hold the request until it is accepted.
- Counters:
  - 4-bit bit counter per field, plus a gap counter of width clog2(GAP_BITS+1).
  - No wrap-around in any counter.

Test Plan:
1. Reset, then port=3, len=2, data=0x0002 → serOut sequence 0,1,1,0,0,1,0,1,0,1,1 from the acceptance edge; busy high for 11 cycles; frameDone pulses on the 10th cycle.
2. Zero length: port=1, len=0 → serOut 0,0,1,0,0,0,0,1,1; busy high for 9 cycles; then IDLE with serOut=1.
3. Maximum length: port=2, len=15, data=0x5555 → data bits 1,0,1,0,…,1 (15 bits) follow 0,1,0,1,1,1,1; busy high for 24 cycles.
4. Back-to-back: frame A (port 0, len 3) accepted, frame B offered on the next cycle:
   - B is accepted; inReady stays low until A's last gap edge.
   - B's start bit follows exactly 2 gap ones; txPort changes from 0 to B's port at B's start.
   - A third request offered while B is held is not accepted until B starts.
5. Reset mid-frame: assert rst=0 during the DATA state with a frame held → serOut=1 and busy=0 immediately (before the next edge); inReady=1. After release, only newly offered frames are transmitted.
6. Input stability: change inData/inLen after acceptance → the transmitted bits match the values captured at acceptance.
